// File: rtl/feature_map_flattener_pkg.sv
// Shared types and constants for the feature-map flattener: FSM state,
// channel count and frame-size helper.
package feature_map_flattener_pkg;

  localparam int CHANNELS = 8;

  typedef enum logic {
    FILL  = 1'b0,
    DRAIN = 1'b1
  } state_e;

  function automatic int frame_size(input int width, input int height);
    return width * height;
  endfunction

endpackage

// File: rtl/feature_map_flattener_store.sv
// Pixel storage: one CHANNELS-bit word per spatial position, synchronous write,
// combinational single-bit read. Contents are deliberately not reset.
module feature_map_store
  import feature_map_flattener_pkg::*;
#(
  parameter int DEPTH = 169,
  parameter int AW    = 8
) (
  input  logic                clk,
  input  logic                we_i,
  input  logic [AW-1:0]       waddr_i,
  input  logic [CHANNELS-1:0] wdata_i,
  input  logic [AW-1:0]       raddr_i,
  input  logic [2:0]          rch_i,
  output logic                rbit_o
);

  logic [CHANNELS-1:0] mem_q [DEPTH];

  // Capture all channels of one pooled pixel.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rbit_o = mem_q[raddr_i][rch_i];

endmodule

// File: rtl/feature_map_flattener.sv
// Collects a binary pooled feature map in raster order, then streams it out
// one bit per handshake in channel-major order.
module feature_map_flattener
  import feature_map_flattener_pkg::*;
#(
  parameter int WIDTH  = 13,
  parameter int HEIGHT = 13
) (
  input  logic clk,
  input  logic rst_n,
  input  logic valid_in,
  input  logic pixel_in_1,
  input  logic pixel_in_2,
  input  logic pixel_in_3,
  input  logic pixel_in_4,
  input  logic pixel_in_5,
  input  logic pixel_in_6,
  input  logic pixel_in_7,
  input  logic pixel_in_8,
  output logic flat_bit,
  output logic flat_valid,
  input  logic flat_ready,
  output logic flat_last,
  output logic frame_busy,
  output logic overflow
);

  localparam int DEPTH = frame_size(WIDTH, HEIGHT);
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);
  localparam logic [AW-1:0] ONE_IDX  = AW'(1);
  localparam logic [2:0]    LAST_CH  = 3'(CHANNELS - 1);

  state_e              state_q;
  logic [AW-1:0]       pix_idx_q;
  logic [AW-1:0]       rd_idx_q;
  logic [2:0]          rd_ch_q;
  logic                overflow_q;
  logic                wr_en;
  logic [CHANNELS-1:0] wr_data;

  assign wr_en   = (state_q == FILL) && valid_in;
  assign wr_data = {pixel_in_8, pixel_in_7, pixel_in_6, pixel_in_5,
                    pixel_in_4, pixel_in_3, pixel_in_2, pixel_in_1};

  // Control FSM: raster fill, then channel-major drain with handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= FILL;
      pix_idx_q  <= '0;
      rd_idx_q   <= '0;
      rd_ch_q    <= 3'd0;
      overflow_q <= 1'b0;
    end else begin
      case (state_q)
        FILL: begin
          if (valid_in) begin
            if (pix_idx_q == LAST_IDX) begin
              pix_idx_q <= '0;
              state_q   <= DRAIN;
            end else begin
              pix_idx_q <= pix_idx_q + ONE_IDX;
            end
          end
        end
        DRAIN: begin
          // Upstream cannot be stalled, so pixels arriving now are lost.
          if (valid_in) begin
            overflow_q <= 1'b1;
          end
          if (flat_ready) begin
            if (rd_idx_q == LAST_IDX) begin
              rd_idx_q <= '0;
              if (rd_ch_q == LAST_CH) begin
                rd_ch_q <= 3'd0;
                state_q <= FILL;
              end else begin
                rd_ch_q <= rd_ch_q + 3'd1;
              end
            end else begin
              rd_idx_q <= rd_idx_q + ONE_IDX;
            end
          end
        end
        default: begin
          state_q <= FILL;
        end
      endcase
    end
  end

  feature_map_store #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_store (
    .clk     (clk),
    .we_i    (wr_en),
    .waddr_i (pix_idx_q),
    .wdata_i (wr_data),
    .raddr_i (rd_idx_q),
    .rch_i   (rd_ch_q),
    .rbit_o  (flat_bit)
  );

  assign flat_valid = (state_q == DRAIN);
  assign frame_busy = (state_q == DRAIN);
  assign flat_last  = (state_q == DRAIN) && (rd_ch_q == LAST_CH) && (rd_idx_q == LAST_IDX);
  assign overflow   = overflow_q;

endmodule
